// File: rtl/window_scan_controller.sv
// window_scan_controller: steps a WIN x WIN window over the frame, loads each window into the classifier engine, and emits its origin downstream.
module window_scan_controller #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int WIN    = 20,
  parameter int STRIDE = 4,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 17
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FRAME_START,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              MEM_RD,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              ENG_WE,
  output logic [4:0]        ENG_ROW,
  output logic [8:0]        ENG_ADDR,
  output logic [DATA_W-1:0] ENG_DATA,
  output logic              ENG_START,
  input  logic              ENG_DONE,
  output logic [8:0]        WIN_X,
  output logic [8:0]        WIN_Y,
  output logic              WIN_VALID,
  input  logic              WIN_READY
);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, KICK, WAIT_ENG, EMIT, ADVANCE} state_t;
  localparam logic [8:0] SX = 9'(STRIDE);
  localparam logic [8:0] LX = 9'(IMG_W - WIN);
  localparam logic [8:0] LY = 9'(IMG_H - WIN);
  localparam logic [4:0] LAST = 5'(WIN - 1);
  localparam logic [MEM_AW-1:0] RSTEP = MEM_AW'(IMG_W);
  localparam logic [MEM_AW-1:0] YSTEP = MEM_AW'(STRIDE * IMG_W);
  state_t state;
  logic [8:0] wx, wy, nx;
  logic [4:0] row, col;
  logic [MEM_AW-1:0] ybase, rbase, nybase;
  logic more_x, more_y;
  assign more_x = wx + SX <= LX;
  assign more_y = wy + SX <= LY;
  assign nx = more_x ? wx + SX : 9'd0;
  assign nybase = more_x ? ybase : ybase + YSTEP;
  // Memory data arrives in the cycle after the read, aligned with the write strobe.
  assign ENG_DATA = ENG_WE ? MEM_DATA : '0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      BUSY <= 1'b0;
      FRAME_DONE <= 1'b0;
      MEM_RD <= 1'b0;
      MEM_ADDR <= '0;
      ENG_WE <= 1'b0;
      ENG_ROW <= '0;
      ENG_ADDR <= '0;
      ENG_START <= 1'b0;
      WIN_X <= '0;
      WIN_Y <= '0;
      WIN_VALID <= 1'b0;
      wx <= '0;
      wy <= '0;
      row <= '0;
      col <= '0;
      ybase <= '0;
      rbase <= '0;
    end else begin
      ENG_WE <= MEM_RD;
      ENG_ROW <= row;
      ENG_ADDR <= 9'(col);
      FRAME_DONE <= 1'b0;
      ENG_START <= 1'b0;
      case (state)
        IDLE: if (FRAME_START && !FRAME_DONE) begin
          state <= FETCH;
          BUSY <= 1'b1;
          MEM_RD <= 1'b1;
          MEM_ADDR <= '0;
          wx <= '0;
          wy <= '0;
          row <= '0;
          col <= '0;
          ybase <= '0;
          rbase <= '0;
        end
        FETCH: if (row == LAST && col == LAST) begin
          state <= DRAIN;
          MEM_RD <= 1'b0;
        end else if (col == LAST) begin
          col <= '0;
          row <= row + 5'd1;
          rbase <= rbase + RSTEP;
          MEM_ADDR <= rbase + RSTEP + MEM_AW'(wx);
        end else begin
          col <= col + 5'd1;
          MEM_ADDR <= MEM_ADDR + 1'b1;
        end
        DRAIN: begin
          state <= KICK;
          ENG_START <= 1'b1;
        end
        KICK: state <= WAIT_ENG;
        WAIT_ENG: if (ENG_DONE) begin
          state <= EMIT;
          WIN_VALID <= 1'b1;
          WIN_X <= wx;
          WIN_Y <= wy;
        end
        EMIT: if (WIN_READY) begin
          state <= ADVANCE;
          WIN_VALID <= 1'b0;
        end
        ADVANCE: if (more_x || more_y) begin
          state <= FETCH;
          MEM_RD <= 1'b1;
          MEM_ADDR <= nybase + MEM_AW'(nx);
          wx <= nx;
          wy <= more_x ? wy : wy + SX;
          row <= '0;
          col <= '0;
          ybase <= nybase;
          rbase <= nybase;
        end else begin
          state <= IDLE;
          BUSY <= 1'b0;
          FRAME_DONE <= 1'b1;
          wx <= '0;
          wy <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
